uart_rx: RTL
============

# uart_rx

Serial receive stage that consumes the 8N1 line produced by `uart_tx` and recovers bytes from it. It synchronises the asynchronous `rx` input and qualifies the start bit at mid-bit. It then samples eight data bits LSB-first at bit centres, checks the stop bit, and presents each byte with a one-cycle valid pulse. It sits between the board/loopback serial pin and the command/data consumer in the SDRAM controller test path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208 (50 MHz / 9600 baud): clock cycles per serial bit. Must be ≥ 8. The bench uses 57 to match the fast-sim transmitter bit period.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  last correctly framed byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in that same cycle.
- `rx_frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `rx_busy`  out  1  high while a frame is in progress (states START, DATA, STOP).

## Operation
- Input conditioning: two-flop synchroniser `rx_s1`→`rx_s2` plus delayed copy `rx_s3`. All three reset to 1. A falling edge is `rx_s3 & ~rx_s2`.
- Constants: `HALF = CLKS_PER_BIT/2`. Bit counter `baud_cnt` width = `$clog2(CLKS_PER_BIT)`. Bit index `bit_idx` is 3 bits.
- IDLE: `baud_cnt = 0`. A falling edge moves the FSM to START. A low level without an edge (line stuck low) is ignored.
- START: count to `HALF-1`, then sample `rx_s2`.
  - If 1: false start; return to IDLE with no output pulse.
  - If 0: go to DATA; `baud_cnt` and `bit_idx` cleared.
- DATA: count to `CLKS_PER_BIT-1`, then sample and shift right into `shift_reg[7]`, giving LSB-first order. `bit_idx` increments; after bit 7 go to STOP.
- STOP: count to `CLKS_PER_BIT-1`, then sample.
  - If 1: `rx_data <= shift_reg`, pulse `rx_valid`.
  - If 0: pulse `rx_frame_err`; `rx_data` unchanged.
  - Either way, return to IDLE in the next cycle.
- After a framing error, reception resumes only on a new falling edge, so a break (line held low) yields exactly one error pulse.
- `rx_valid` and `rx_frame_err` are never high together.
- Reset (any cycle, including mid-frame): state IDLE, counters 0, `shift_reg` 0. Outputs: `rx_data = 8'h00`, `rx_valid = 0`, `rx_frame_err = 0`, `rx_busy = 0`. A partially received frame is discarded silently.

## Timing
- Synchroniser latency: 2 cycles from a raw `rx` edge to `rx_s2`. Edge detect adds 1 cycle.
- Start-bit sample is taken `HALF` cycles after entering START. Each data sample and the stop sample follow at `CLKS_PER_BIT`-cycle intervals, so samples sit at bit centres ± 1 cycle.
- `rx_valid` pulses 3 + HALF + 9·CLKS_PER_BIT cycles (±1) after the raw start-bit falling edge. With 57 cycles per bit this is 544 ± 1.
- Back-to-back frames: the FSM is back in IDLE about `HALF` cycles before the next start edge, so there is no lost byte at zero idle gap.
- Tolerance: correct for a transmitter bit period within ±4 % of `CLKS_PER_BIT`.
- `rx_busy` rises the cycle after edge detect. It falls the cycle after the stop sample or after a false start.

## Structure
- Shared package `uart_pkg`:
  - `FPGA_FREQ` (50_000_000), `BAUD_RATE` (9600), derived `CLKS_PER_BIT`, and the sim override value 57.
  - FSM state typedef `{IDLE, START, DATA, STOP}`.
  - This package is also imported by the transmitter so both ends share one bit period.
- Sub-module `uart_rx_sync`: 2-FF synchroniser plus falling-edge detector. Outputs `rx_sync` and `rx_fall`; reused by future RX-side blocks.
- Main body: FSM, `baud_cnt`, `bit_idx`, shift register, output registers.

## Test plan
- Single byte 8'hA5, ideal 57-cycle bits, idle before and after → exactly one `rx_valid` with `rx_data = 8'hA5`, 544 ± 1 cycles after the start edge; `rx_frame_err` stays 0.
- Loopback from the transmitter sending 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap → three `rx_valid` pulses, data in order, no errors.
- Glitch: `rx` low for 20 cycles, then high → no `rx_valid` or `rx_frame_err`; `rx_busy` returns to 0 within 30 cycles.
- Stop bit forced low on byte 8'h3C, then line held low 2000 cycles → one `rx_frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value. The next proper frame 8'h81 is received correctly.
- `rstn` asserted during data bit 4 of 8'hC3 → next cycle all outputs at reset values. The next full frame 8'h12 is received correctly and the aborted byte never appears.
- Bit-period skew: frames 8'h96 at 55 and 59 cycles per bit → both received as 8'h96 without error.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state type for the TX and RX ends
package uart_pkg;

  // Rounded integer division keeps the bit period closest to the nominal baud rate.
  function automatic int clks_per_bit_calc(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

  localparam int FPGA_FREQ        = 50_000_000;
  localparam int BAUD_RATE        = 9600;
  localparam int CLKS_PER_BIT     = clks_per_bit_calc(FPGA_FREQ, BAUD_RATE);
  localparam int SIM_CLKS_PER_BIT = 57;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser and falling-edge detector for the serial line
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  // Resync the raw line and keep one delayed copy; all stages idle high so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_sync = rx_s2;
  // Only a high-to-low transition counts; a line stuck low never re-triggers.
  assign rx_fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and framing-error detection
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_t state;
  uart_state_t state_nxt;

  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic rx_sync;
  logic rx_fall;

  logic half_done;
  logic bit_done;
  logic cnt_clr;
  logic shift_en;
  logic frame_ok;
  logic frame_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  assign half_done = (baud_cnt == CNT_W'(HALF - 1));
  assign bit_done  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; the counter restarts whenever a sample point is reached.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_fall) begin
          state_nxt = START;
        end
      end
      START: begin
        if (half_done) begin
          cnt_clr = 1'b1;
          // A line back high at mid start bit was a glitch, not a frame.
          state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
          frame_ok  = rx_sync;
          frame_bad = ~rx_sync;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Baud counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + CNT_W'(1);
      if (state == START) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
      end
    end
  end

  // Output registers: data updates only on a good frame; the two pulses are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= frame_ok;
      rx_frame_err <= frame_bad;
      if (frame_ok) begin
        rx_data <= shift_reg;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
